// File: rtl/wb_rr_arbiter2_if.sv
// Wishbone link bundle: request fields flow master->slave, response fields flow back.
// Pipelined flow control via stall; rty is carried for slaves that issue it.
interface wb_rr_arbiter2_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                      cyc;
    logic                      stb;
    logic                      we;
    logic [ADDR_WIDTH-1:0]     adr;
    logic [DATA_WIDTH/8-1:0]   sel;
    logic [DATA_WIDTH-1:0]     dat_w;
    logic [DATA_WIDTH-1:0]     dat_r;
    logic                      ack;
    logic                      err;
    logic                      rty;
    logic                      stall;

    modport master (
        output cyc, stb, we, adr, sel, dat_w,
        input  dat_r, ack, err, rty, stall
    );

    modport slave (
        input  cyc, stb, we, adr, sel, dat_w,
        output dat_r, ack, err, rty, stall
    );
endinterface

// File: rtl/wb_rr_arbiter2.sv
// Round-robin 2:1 Wishbone arbiter, one transaction in flight; response reaches the owner
// one cycle after the slave answers (3-cycle minimum turnaround), stall holds stb, watchdog ends WAIT.
module wb_rr_arbiter2 #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int TIMEOUT    = 255
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    wb_rr_arbiter2_if.slave       m0,
    wb_rr_arbiter2_if.slave       m1,
    wb_rr_arbiter2_if.master      s,
    output logic                  busy_o
);
    localparam int          SEL_WIDTH = DATA_WIDTH / 8;
    localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

    state_t                  state_q, state_d;
    logic                    owner_q, owner_d;
    logic                    last_q, last_d;
    logic [15:0]             cnt_q, cnt_d;
    logic                    s_cyc_q, s_cyc_d;
    logic                    s_stb_q, s_stb_d;
    logic                    s_we_q, s_we_d;
    logic [ADDR_WIDTH-1:0]   s_adr_q, s_adr_d;
    logic [SEL_WIDTH-1:0]    s_sel_q, s_sel_d;
    logic [DATA_WIDTH-1:0]   s_dat_q, s_dat_d;
    logic [DATA_WIDTH-1:0]   rdat_q, rdat_d;
    logic                    ack0_q, ack0_d, err0_q, err0_d;
    logic                    ack1_q, ack1_d, err1_q, err1_d;
    logic                    busy_q, busy_d;

    logic req0, req1, win, fin, fin_ok;

    assign req0 = m0.cyc & m0.stb;
    assign req1 = m1.cyc & m1.stb;
    // On a tie the requester that did not win last time goes next.
    assign win  = (req0 & req1) ? ~last_q : req1;

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        s_cyc_d = s_cyc_q;
        s_stb_d = s_stb_q;
        s_we_d  = s_we_q;
        s_adr_d = s_adr_q;
        s_sel_d = s_sel_q;
        s_dat_d = s_dat_q;
        rdat_d  = rdat_q;
        ack0_d  = 1'b0;
        err0_d  = 1'b0;
        ack1_d  = 1'b0;
        err1_d  = 1'b0;
        fin     = 1'b0;
        fin_ok  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req0 | req1) begin
                    s_adr_d = win ? m1.adr   : m0.adr;
                    s_sel_d = win ? m1.sel   : m0.sel;
                    s_dat_d = win ? m1.dat_w : m0.dat_w;
                    s_we_d  = win ? m1.we    : m0.we;
                    owner_d = win;
                    last_d  = win;
                    s_cyc_d = 1'b1;
                    s_stb_d = 1'b1;
                    state_d = ISSUE;
                end
            end
            ISSUE, WAIT: begin
                // The slave may answer in the same cycle it drops stall, so ISSUE checks responses too.
                if (s.ack) begin
                    fin    = 1'b1;
                    fin_ok = 1'b1;
                    rdat_d = s.dat_r;
                end else if (s.err | s.rty) begin
                    fin = 1'b1;
                end else if (state_q == WAIT && cnt_q == TO_LAST) begin
                    fin = 1'b1;
                end
                if (fin) begin
                    state_d = DONE;
                    s_cyc_d = 1'b0;
                    s_stb_d = 1'b0;
                    ack0_d  = fin_ok & ~owner_q;
                    err0_d  = ~fin_ok & ~owner_q;
                    ack1_d  = fin_ok & owner_q;
                    err1_d  = ~fin_ok & owner_q;
                end else if (state_q == ISSUE) begin
                    if (!s.stall) begin
                        state_d = WAIT;
                        s_stb_d = 1'b0;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            owner_q <= 1'b0;
            last_q  <= 1'b1;
            cnt_q   <= '0;
            s_cyc_q <= 1'b0;
            s_stb_q <= 1'b0;
            s_we_q  <= 1'b0;
            s_adr_q <= '0;
            s_sel_q <= '0;
            s_dat_q <= '0;
            rdat_q  <= '0;
            ack0_q  <= 1'b0;
            err0_q  <= 1'b0;
            ack1_q  <= 1'b0;
            err1_q  <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            s_cyc_q <= s_cyc_d;
            s_stb_q <= s_stb_d;
            s_we_q  <= s_we_d;
            s_adr_q <= s_adr_d;
            s_sel_q <= s_sel_d;
            s_dat_q <= s_dat_d;
            rdat_q  <= rdat_d;
            ack0_q  <= ack0_d;
            err0_q  <= err0_d;
            ack1_q  <= ack1_d;
            err1_q  <= err1_d;
            busy_q  <= busy_d;
        end
    end

    assign s.cyc    = s_cyc_q;
    assign s.stb    = s_stb_q;
    assign s.we     = s_we_q;
    assign s.adr    = s_adr_q;
    assign s.sel    = s_sel_q;
    assign s.dat_w  = s_dat_q;

    assign m0.ack   = ack0_q;
    assign m0.err   = err0_q;
    assign m0.dat_r = rdat_q;
    assign m0.rty   = 1'b0;
    assign m0.stall = 1'b0;
    assign m1.ack   = ack1_q;
    assign m1.err   = err1_q;
    assign m1.dat_r = rdat_q;
    assign m1.rty   = 1'b0;
    assign m1.stall = 1'b0;

    assign busy_o   = busy_q;
endmodule

// File: tb/tb_wb_rr_arbiter2.sv
// Directed transaction table plus hand-written reset and round-robin sequences for wb_rr_arbiter2.
module tb_wb_rr_arbiter2;
    logic clk;
    logic rst_i;
    logic busy_o;

    wb_rr_arbiter2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m0_if ();
    wb_rr_arbiter2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) m1_if ();
    wb_rr_arbiter2_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) s_if ();

    wb_rr_arbiter2 #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT(8)) dut (
        .clk_i (clk),
        .rst_i (rst_i),
        .m0    (m0_if),
        .m1    (m1_if),
        .s     (s_if),
        .busy_o(busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // resp bits: {ack, err, rty}; rdly = cycles after stb acceptance; xcyc = pulse cycle after grant
    typedef struct {
        logic        r0, r1, we0, we1;
        logic [31:0] a0, a1, d0, d1;
        int          stall;
        logic [2:0]  resp;
        int          rdly;
        logic [31:0] rdat;
        logic        xo, xack;
        int          xcyc;
    } vec_t;

    function automatic vec_t mk(logic r0, logic r1, logic we0, logic we1,
                                logic [31:0] a0, logic [31:0] a1, logic [31:0] d0, logic [31:0] d1,
                                int stall, logic [2:0] resp, int rdly, logic [31:0] rdat,
                                logic xo, logic xack, int xcyc);
        vec_t v;
        v.r0 = r0; v.r1 = r1; v.we0 = we0; v.we1 = we1;
        v.a0 = a0; v.a1 = a1; v.d0 = d0; v.d1 = d1;
        v.stall = stall; v.resp = resp; v.rdly = rdly; v.rdat = rdat;
        v.xo = xo; v.xack = xack; v.xcyc = xcyc;
        return v;
    endfunction

    task automatic clear_inputs();
        m0_if.cyc = 0; m0_if.stb = 0; m0_if.we = 0; m0_if.adr = 0; m0_if.sel = 0; m0_if.dat_w = 0;
        m1_if.cyc = 0; m1_if.stb = 0; m1_if.we = 0; m1_if.adr = 0; m1_if.sel = 0; m1_if.dat_w = 0;
        s_if.ack = 0; s_if.err = 0; s_if.rty = 0; s_if.stall = 0; s_if.dat_r = 0;
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int stbs, pc;
        bit seen, fin, act;
        logic [31:0] xa, xd;
        logic xwe;
        logic [3:0] xsel;
        xa   = v.xo ? v.a1 : v.a0;
        xd   = v.xo ? v.d1 : v.d0;
        xwe  = v.xo ? v.we1 : v.we0;
        xsel = v.xo ? 4'h3 : 4'hF;
        m0_if.cyc = v.r0; m0_if.stb = v.r0; m0_if.we = v.we0; m0_if.adr = v.a0; m0_if.dat_w = v.d0; m0_if.sel = 4'hF;
        m1_if.cyc = v.r1; m1_if.stb = v.r1; m1_if.we = v.we1; m1_if.adr = v.a1; m1_if.dat_w = v.d1; m1_if.sel = 4'h3;
        s_if.stall = (v.stall > 0);
        s_if.ack = 0; s_if.err = 0; s_if.rty = 0;
        stbs = 0; pc = 0; seen = 0; fin = 0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                check($sformatf("v%0d issue cyc", idx), s_if.cyc, 1);
                check($sformatf("v%0d issue adr", idx), s_if.adr, xa);
                check($sformatf("v%0d issue we", idx), s_if.we, xwe);
                check($sformatf("v%0d issue dat", idx), s_if.dat_w, xd);
                check($sformatf("v%0d issue sel", idx), s_if.sel, xsel);
                check($sformatf("v%0d issue busy", idx), busy_o, 1);
            end
            if (s_if.stb) stbs++;
            act = (v.resp != 3'b000) && (c == v.stall + 1 + v.rdly);
            s_if.stall = (c <= v.stall);
            s_if.ack   = act & v.resp[2];
            s_if.err   = act & v.resp[1];
            s_if.rty   = act & v.resp[0];
            s_if.dat_r = act ? v.rdat : (32'h5A5A_0000 + 32'(c));
            if (seen) begin
                check($sformatf("v%0d pulse width", idx),
                      {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, 4'b0000);
                fin = 1;
            end else if (m0_if.ack | m0_if.err | m1_if.ack | m1_if.err) begin
                seen = 1;
                pc   = c;
                check($sformatf("v%0d pulse cycle", idx), pc, v.xcyc);
                check($sformatf("v%0d owner ack", idx), v.xo ? m1_if.ack : m0_if.ack, v.xack);
                check($sformatf("v%0d owner err", idx), v.xo ? m1_if.err : m0_if.err, !v.xack);
                check($sformatf("v%0d other quiet", idx),
                      v.xo ? {m0_if.ack, m0_if.err} : {m1_if.ack, m1_if.err}, 2'b00);
                check($sformatf("v%0d cyc low in done", idx), s_if.cyc, 0);
                if (v.xack)
                    check($sformatf("v%0d read data", idx), v.xo ? m1_if.dat_r : m0_if.dat_r, v.rdat);
                m0_if.cyc = 0; m0_if.stb = 0;
                m1_if.cyc = 0; m1_if.stb = 0;
            end
        end
        check($sformatf("v%0d response seen", idx), seen, 1);
        check($sformatf("v%0d stb cycles", idx), stbs, v.stall + 1);
        clear_inputs();
        repeat (2) begin @(posedge clk); #1; end
    endtask

    vec_t vecs[10];

    initial begin
        #500000;
        $display("FAIL global timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int pulses, cycs, n, lastg, a0c, a1c;
        bit fin;
        logic [31:0] ga[4];
        logic [31:0] gd[4];

        //            r0 r1 we0 we1 a0          a1          d0            d1            st resp    rd rdat          xo xack xcyc
        vecs[0] = mk(1, 0, 0, 0, 32'h10,     32'h0,      32'h0,        32'h0,        0, 3'b100, 1, 32'hDEADBEEF, 0, 1, 3);
        vecs[1] = mk(0, 1, 0, 1, 32'h0,      32'h24,     32'h0,        32'h11223344, 0, 3'b100, 0, 32'h0,        1, 1, 2);
        vecs[2] = mk(1, 0, 1, 0, 32'h30,     32'h0,      32'h55667788, 32'h0,        3, 3'b100, 1, 32'h0,        0, 1, 6);
        vecs[3] = mk(0, 1, 0, 0, 32'h0,      32'h44,     32'h0,        32'h0,        0, 3'b010, 2, 32'h0,        1, 0, 4);
        vecs[4] = mk(0, 1, 0, 0, 32'h0,      32'h48,     32'h0,        32'h0,        0, 3'b001, 0, 32'h0,        1, 0, 2);
        vecs[5] = mk(1, 0, 0, 0, 32'h50,     32'h0,      32'h0,        32'h0,        0, 3'b000, 0, 32'h0,        0, 0, 10);
        vecs[6] = mk(1, 1, 0, 0, 32'h60,     32'h64,     32'h0,        32'h0,        0, 3'b100, 1, 32'h0BADCAFE, 1, 1, 3);
        vecs[7] = mk(1, 1, 1, 0, 32'h70,     32'h74,     32'h0A0B0C0D, 32'h0,        0, 3'b100, 3, 32'h13579BDF, 0, 1, 5);
        vecs[8] = mk(1, 0, 0, 0, 32'h78,     32'h0,      32'h0,        32'h0,        0, 3'b110, 1, 32'hCAFEF00D, 0, 1, 3);
        vecs[9] = mk(0, 1, 0, 0, 32'h0,      32'h7C,     32'h0,        32'h0,        0, 3'b011, 1, 32'h0,        1, 0, 3);

        clear_inputs();
        rst_i = 1;
        repeat (3) @(posedge clk);
        #1;
        check("reset s_cyc/stb/we", {s_if.cyc, s_if.stb, s_if.we}, 3'b000);
        check("reset s_adr", s_if.adr, 0);
        check("reset s_dat/sel", {s_if.dat_w, s_if.sel}, 0);
        check("reset m strobes", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, 4'b0000);
        check("reset m dat", {m0_if.dat_r, m1_if.dat_r}, 0);
        check("reset busy", busy_o, 0);
        rst_i = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) run_vec(i, vecs[i]);

        // Reset asserted while the transaction sits in WAIT.
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.adr = 32'h80; m1_if.sel = 4'h3;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check("rst seq busy in wait", busy_o, 1);
        check("rst seq cyc/stb in wait", {s_if.cyc, s_if.stb}, 2'b10);
        rst_i = 1;
        @(posedge clk); #1;
        check("rst seq s outputs", {s_if.cyc, s_if.stb, s_if.we, s_if.sel}, 0);
        check("rst seq s adr", s_if.adr, 0);
        check("rst seq busy", busy_o, 0);
        check("rst seq m dat", m0_if.dat_r, 0);
        check("rst seq m strobes", {m0_if.ack, m0_if.err, m1_if.ack, m1_if.err}, 4'b0000);
        rst_i = 0;
        m1_if.cyc = 0; m1_if.stb = 0;
        s_if.ack = 1; s_if.dat_r = 32'hFEEDFACE;
        pulses = 0; cycs = 0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (m0_if.ack | m0_if.err | m1_if.ack | m1_if.err) pulses++;
            if (s_if.cyc) cycs++;
            s_if.ack = 0;
        end
        check("late ack no pulse", pulses, 0);
        check("late ack no cycle", cycs, 0);

        // Both requesters hold their requests; slave acks as soon as stb is out.
        m0_if.cyc = 1; m0_if.stb = 1; m0_if.we = 1; m0_if.adr = 32'h100; m0_if.dat_w = 32'hA0A00001; m0_if.sel = 4'hF;
        m1_if.cyc = 1; m1_if.stb = 1; m1_if.we = 0; m1_if.adr = 32'h200; m1_if.dat_w = 32'hB0B00002; m1_if.sel = 4'h3;
        s_if.ack = 1; s_if.dat_r = 32'h12345678;
        n = 0; lastg = -100; a0c = 0; a1c = 0; fin = 0;
        for (int c = 1; c <= 40 && !fin; c++) begin
            @(posedge clk); #1;
            if (m0_if.ack) a0c++;
            if (m1_if.ack) a1c++;
            if (n == 4 && c == lastg + 1) fin = 1;
            else if (s_if.stb && n < 4) begin
                ga[n] = s_if.adr;
                gd[n] = s_if.dat_w;
                n++;
                lastg = c;
            end
        end
        clear_inputs();
        check("rr grant count", n, 4);
        check("rr grant0 adr", ga[0], 32'h100);
        check("rr grant1 adr", ga[1], 32'h200);
        check("rr grant2 adr", ga[2], 32'h100);
        check("rr grant3 adr", ga[3], 32'h200);
        check("rr grant0 dat", gd[0], 32'hA0A00001);
        check("rr grant1 dat", gd[1], 32'hB0B00002);
        check("rr m0 acks", a0c, 2);
        check("rr m1 acks", a1c, 2);
        repeat (2) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
